// File: rtl/dcache_pkg.sv
// Shared types and helpers for the write-back data cache: FSM state, derived
// address-field widths and the byte-lane merge used on write hits.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int lines, input int line_words);
        return addr_w - $clog2(lines) - $clog2(line_words);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = be[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data store: two asynchronous read ports (core word, writeback word)
// and one synchronous byte-enable write port. Contents are not reset.
module dcache_data_ram
    import dcache_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [31:0]   rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [31:0]   rdata_b
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= byte_merge(mem[waddr], wdata, be);

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with burst writeback/refill.
// Define DCACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    input  logic [31:0]       mem_rdata
);

    localparam int OFF_W = off_w(LINE_WORDS);
    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(ADDR_W, LINES, LINE_WORDS);

    state_t            state;
    logic [OFF_W-1:0]  cnt;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              from_refill;
    logic [TAG_W-1:0]  tags [LINES];
    logic [LINES-1:0]  valid, dirty;

    logic [OFF_W-1:0]  req_off, cnt_inc, rd_b_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag, old_tag;
    logic              hit, last, beat_ok;
    logic [31:0]       rd_a, rd_b;

    logic                   ram_we;
    logic [3:0]             ram_be;
    logic [IDX_W+OFF_W-1:0] ram_waddr;
    logic [31:0]            ram_wdata;

    assign req_off  = req_addr[OFF_W-1:0];
    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
    assign old_tag  = tags[req_idx];
    assign hit      = valid[req_idx] && (old_tag == req_tag);
    assign cnt_inc  = cnt + 1'b1;
    assign last     = &cnt;
    assign beat_ok  = mem_valid && mem_ready;
    // Port b pre-fetches the word for the next writeback beat (word 0 on entry).
    assign rd_b_off = (state == WRITEBACK) ? cnt_inc : '0;

    assign cpu_req_ready = (state == IDLE);

    always_comb begin
        ram_we    = 1'b0;
        ram_be    = 4'hF;
        ram_waddr = {req_idx, cnt};
        ram_wdata = mem_rdata;
        if (state == COMPARE && hit && req_we) begin
            ram_we    = 1'b1;
            ram_be    = req_be;
            ram_waddr = {req_idx, req_off};
            ram_wdata = req_wdata;
        end else if (state == REFILL && beat_ok) begin
            ram_we    = 1'b1;
        end
    end

    dcache_data_ram #(.DEPTH(LINES*LINE_WORDS), .AW(IDX_W+OFF_W)) u_data (
        .clk     (clk),
        .we      (ram_we),
        .be      (ram_be),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a ({req_idx, req_off}),
        .rdata_a (rd_a),
        .raddr_b ({req_idx, rd_b_off}),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk)
        if (state == REFILL && beat_ok && last) tags[req_idx] <= req_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            req_addr    <= '0;
            req_we      <= 1'b0;
            req_be      <= '0;
            req_wdata   <= '0;
            from_refill <= 1'b0;
            valid       <= '0;
            dirty       <= '0;
            cpu_rvalid  <= 1'b0;
            cpu_rdata   <= '0;
            mem_valid   <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            unique case (state)
                IDLE: if (cpu_req_valid) begin
                    req_addr    <= cpu_addr;
                    req_we      <= cpu_we;
                    req_be      <= cpu_be;
                    req_wdata   <= cpu_wdata;
                    from_refill <= 1'b0;
                    cnt         <= '0;
                    state       <= COMPARE;
                end
                COMPARE: begin
                    cnt <= '0;
                    if (hit) begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= rd_a;
                        if (req_we) dirty[req_idx] <= 1'b1;
                        state <= IDLE;
                    end else if (valid[req_idx] && dirty[req_idx]) begin
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {old_tag, req_idx, {OFF_W{1'b0}}};
                        mem_wdata <= rd_b;
                        state     <= WRITEBACK;
                    end else begin
                        mem_valid <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state     <= REFILL;
                    end
                end
                WRITEBACK: if (beat_ok) begin
                    if (last) begin
                        dirty[req_idx] <= 1'b0;
                        cnt       <= '0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_addr  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state     <= REFILL;
                    end else begin
                        cnt       <= cnt_inc;
                        mem_addr  <= {old_tag, req_idx, cnt_inc};
                        mem_wdata <= rd_b;
                    end
                end
                REFILL: if (beat_ok) begin
                    if (last) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        from_refill    <= 1'b1;
                        cnt       <= '0;
                        mem_valid <= 1'b0;
                        mem_addr  <= '0;
                        state     <= COMPARE;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_addr <= {req_tag, req_idx, cnt_inc};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    // The post-refill lookup is the tail of a miss, not a separate hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == COMPARE) begin
            if (hit && !from_refill && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            if (!hit && miss_cnt != '1)               miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: refill, hits, writeback, stalls, reset mid-burst.
module tb_dcache_wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic [29:0] cpu_addr = '0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    // Backing memory: word = 0xA0 + 0x10*addr[9:8] + addr[1:0].
    assign mem_rdata = 32'hA0 + 32'(mem_addr[9:8]) * 32'd16 + 32'(mem_addr[1:0]);

    dcache_wb dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_addr      (cpu_addr),
        .cpu_we        (cpu_we),
        .cpu_be        (cpu_be),
        .cpu_wdata     (cpu_wdata),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
`ifdef DCACHE_STATS_EN
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt),
`endif
        .mem_rdata     (mem_rdata)
    );

    int          n_cmp = 0, n_bad = 0;
    int          nb, cyc, stall_at = -1, stall_left = 0;
    logic [29:0] stall_addr = '0;
    logic [31:0] rd;
    logic [29:0] b_addr [16];
    logic        b_we   [16];
    logic [31:0] b_data [16];
    logic [31:0] exp_wb [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one request from an IDLE cycle; log accepted memory beats until the response.
    task automatic do_req(input logic [29:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd);
        logic done;
        cpu_req_valid = 1'b1; cpu_addr = a; cpu_we = w; cpu_be = be; cpu_wdata = wd;
        nb = 0; cyc = -1; rd = 'x; done = 1'b0;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (cpu_rvalid) begin
                rd = cpu_rdata; cyc = i; done = 1'b1;
            end else begin
                if (mem_valid && nb == stall_at && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                    chk("stall_valid", 32'(mem_valid), 32'd1);
                    chk("stall_addr", 32'(mem_addr), 32'(stall_addr));
                    chk("stall_we", 32'(mem_we), 32'd0);
                end else begin
                    mem_ready = 1'b1;
                end
                if (mem_valid && mem_ready && nb < 16) begin
                    b_addr[nb] = mem_addr; b_we[nb] = mem_we; b_data[nb] = mem_wdata;
                    nb++;
                end
                @(posedge clk); #1;
            end
        end
        mem_ready = 1'b1;
        chk("rvalid_seen", 32'(done), 32'd1);
    endtask

    initial begin
        logic found;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mvalid", 32'(mem_valid), 32'd0);
        chk("rst_mwe", 32'(mem_we), 32'd0);
        chk("rst_maddr", 32'(mem_addr), 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(cpu_req_ready), 32'd1);

        // 1: cold read miss then hit in same line
        do_req(30'h10, 1'b0, 4'h0, 32'h0);
        chk("t1_rdata", rd, 32'h000000A0);
        chk("t1_beats", 32'(nb), 32'd4);
        chk("t1_lat", 32'(cyc), 32'd6);
        for (int k = 0; k < 4; k++) begin
            chk("t1_baddr", 32'(b_addr[k]), 32'h10 + 32'(k));
            chk("t1_bwe", 32'(b_we[k]), 32'd0);
        end
        do_req(30'h11, 1'b0, 4'h0, 32'h0);
        chk("t1_hit_rdata", rd, 32'h000000A1);
        chk("t1_hit_lat", 32'(cyc), 32'd1);
        chk("t1_hit_beats", 32'(nb), 32'd0);

        // 2: partial write hit returns the pre-write word
        do_req(30'h12, 1'b1, 4'b0011, 32'hFFFF1234);
        chk("t2_wr_old", rd, 32'h000000A2);
        chk("t2_wr_beats", 32'(nb), 32'd0);
        chk("t2_wr_lat", 32'(cyc), 32'd1);
        do_req(30'h12, 1'b0, 4'h0, 32'h0);
        chk("t2_rd_merged", rd, 32'h00001234);
`ifdef DCACHE_STATS_EN
        chk("stats_hit", hit_cnt, 32'd3);
        chk("stats_miss", miss_cnt, 32'd1);
`endif

        // 3: conflict miss on dirty line -> writeback then refill
        exp_wb[0] = 32'hA0; exp_wb[1] = 32'hA1; exp_wb[2] = 32'h1234; exp_wb[3] = 32'hA3;
        do_req(30'h110, 1'b0, 4'h0, 32'h0);
        chk("t3_rdata", rd, 32'h000000B0);
        chk("t3_beats", 32'(nb), 32'd8);
        chk("t3_lat", 32'(cyc), 32'd10);
        for (int k = 0; k < 4; k++) begin
            chk("t3_wb_addr", 32'(b_addr[k]), 32'h10 + 32'(k));
            chk("t3_wb_we", 32'(b_we[k]), 32'd1);
            chk("t3_wb_data", b_data[k], exp_wb[k]);
            chk("t3_rf_addr", 32'(b_addr[k+4]), 32'h110 + 32'(k));
            chk("t3_rf_we", 32'(b_we[k+4]), 32'd0);
        end

        // 4: clean conflict miss, refill beat 1 stalled 5 cycles
        stall_at = 1; stall_left = 5; stall_addr = 30'h211;
        do_req(30'h210, 1'b0, 4'h0, 32'h0);
        stall_at = -1;
        chk("t4_rdata", rd, 32'h000000C0);
        chk("t4_beats", 32'(nb), 32'd4);
        chk("t4_lat", 32'(cyc), 32'd11);
        chk("t4_b1_addr", 32'(b_addr[1]), 32'h211);
        chk("t4_b3_addr", 32'(b_addr[3]), 32'h213);

        // 5: be=0 write still dirties; reset during writeback discards it
        do_req(30'h10, 1'b1, 4'h0, 32'hDEADBEEF);
        chk("t5_wr_old", rd, 32'h000000A0);
        chk("t5_wr_beats", 32'(nb), 32'd4);
        do_req(30'h10, 1'b0, 4'h0, 32'h0);
        chk("t5_be0_data", rd, 32'h000000A0);
        cpu_req_valid = 1'b1; cpu_addr = 30'h110; cpu_we = 1'b0;
        @(posedge clk); #1;
        cpu_req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_valid && mem_we && mem_addr == 30'h12) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("t5_wb_beat2_seen", 32'(found), 32'd1);
        chk("t5_wb_beat2_data", mem_wdata, 32'h000000A2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_mvalid", 32'(mem_valid), 32'd0);
        chk("t5_async_mwe", 32'(mem_we), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_ready", 32'(cpu_req_ready), 32'd1);
        do_req(30'h110, 1'b0, 4'h0, 32'h0);
        chk("t5_rdata", rd, 32'h000000B0);
        chk("t5_beats", 32'(nb), 32'd4);
        chk("t5_lat", 32'(cyc), 32'd6);
        chk("t5_b0_addr", 32'(b_addr[0]), 32'h110);
        chk("t5_b0_we", 32'(b_we[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
